// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - micro-program counter with dispatch, jumps, call/return stack and halt
module microcode_sequencer #(
  parameter int                 UPC_W       = 6,
  parameter logic [UPC_W-1:0]   RESET_ADDR  = '0,
  parameter logic [UPC_W-1:0]   FETCH_ADDR  = '0,
  parameter int                 STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [UPC_W-1:0] rom_offset,
  input  logic [2:0]       uc_seq,
  input  logic [UPC_W-1:0] uc_target,
  input  logic [1:0]       uc_cond,
  input  logic             flag_z,
  input  logic             flag_c,
  input  logic             flag_n,
  input  logic             resume,
  output logic [UPC_W-1:0] upc,
  output logic             dispatch,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       depth
);

  localparam int         SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [3:0] FULL = 4'(STACK_DEPTH);

  localparam logic [2:0] SEQ_NEXT     = 3'd0;
  localparam logic [2:0] SEQ_DISPATCH = 3'd1;
  localparam logic [2:0] SEQ_JUMP     = 3'd2;
  localparam logic [2:0] SEQ_CJUMP    = 3'd3;
  localparam logic [2:0] SEQ_FETCH    = 3'd4;
  localparam logic [2:0] SEQ_HALT     = 3'd5;
  localparam logic [2:0] SEQ_CALL     = 3'd6;
  localparam logic [2:0] SEQ_RET      = 3'd7;

  typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [3:0]       cnt_m1;
  logic [UPC_W-1:0] upc_inc;
  logic [UPC_W-1:0] stack_mem [STACK_DEPTH];
  logic             cond_ok;
  logic             step_en;
  logic             push;

  assign upc_inc  = upc + {{(UPC_W-1){1'b0}}, 1'b1};
  assign cnt_m1   = cnt - 4'd1;
  assign step_en  = (state == S_RUN) && !stall;
  assign dispatch = step_en && (uc_seq == SEQ_DISPATCH);
  assign push     = step_en && (uc_seq == SEQ_CALL) && (cnt != FULL);
  // A full stack of 8 reads back as 0 on the 3-bit depth port.
  assign depth    = cnt[2:0];

  always_comb begin
    cond_ok = 1'b0;
    case (uc_cond)
      2'd0:    cond_ok = 1'b1;
      2'd1:    cond_ok = flag_z;
      2'd2:    cond_ok = flag_c;
      default: cond_ok = flag_n;
    endcase
  end

  // Stack storage is kept out of the reset domain; only cnt defines validity.
  always_ff @(posedge clk) begin
    if (push) stack_mem[cnt[SP_W-1:0]] <= upc_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc    <= RESET_ADDR;
      cnt    <= 4'd0;
      state  <= S_RUN;
      halted <= 1'b0;
      fault  <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (!stall) begin
            case (uc_seq)
              SEQ_NEXT:     upc <= upc_inc;
              SEQ_DISPATCH: upc <= rom_offset;
              SEQ_JUMP:     upc <= uc_target;
              SEQ_CJUMP:    upc <= cond_ok ? uc_target : upc_inc;
              SEQ_FETCH:    upc <= FETCH_ADDR;
              SEQ_HALT: begin
                state  <= S_HALT;
                halted <= 1'b1;
              end
              SEQ_CALL: begin
                if (cnt == FULL) begin
                  state <= S_FAULT;
                  fault <= 1'b1;
                end else begin
                  upc <= uc_target;
                  cnt <= cnt + 4'd1;
                end
              end
              default: begin
                if (cnt == 4'd0) begin
                  state <= S_FAULT;
                  fault <= 1'b1;
                end else begin
                  upc <= stack_mem[cnt_m1[SP_W-1:0]];
                  cnt <= cnt_m1;
                end
              end
            endcase
          end
        end
        S_HALT: begin
          if (resume) begin
            upc    <= FETCH_ADDR;
            state  <= S_RUN;
            halted <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb/tb_microcode_sequencer.sv - directed self-checking bench for microcode_sequencer
module tb_microcode_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall;
  logic [5:0] rom_offset;
  logic [2:0] uc_seq;
  logic [5:0] uc_target;
  logic [1:0] uc_cond;
  logic       flag_z, flag_c, flag_n;
  logic       resume;
  logic [5:0] upc;
  logic       dispatch, halted, fault;
  logic [2:0] depth;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] NEXT = 3'd0, DISP = 3'd1, JUMP = 3'd2, CJMP = 3'd3;
  localparam logic [2:0] FTCH = 3'd4, HALT = 3'd5, CALL = 3'd6, RET = 3'd7;

  microcode_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .rom_offset(rom_offset),
    .uc_seq(uc_seq), .uc_target(uc_target), .uc_cond(uc_cond),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .resume(resume),
    .upc(upc), .dispatch(dispatch), .halted(halted), .fault(fault), .depth(depth)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [2:0] seq, input logic [5:0] tgt, input logic [1:0] cond);
    uc_seq = seq; uc_target = tgt; uc_cond = cond;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    step(JUMP, 6'h2A, 2'd0);
    step(CALL, 6'h2A, 2'd0);
    total++; if (upc !== 6'h2A || depth !== 3'd1) begin bad++; $display("FAIL pre_reset upc=%h depth=%0d want 2a/1", upc, depth); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (upc !== 6'h00) begin bad++; $display("FAIL reset_upc got %h want 00", upc); end
    total++; if (depth !== 3'd0 || halted !== 1'b0 || fault !== 1'b0)
      begin bad++; $display("FAIL reset_flags depth=%0d halted=%b fault=%b want 0/0/0", depth, halted, fault); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_next();
    step(JUMP, 6'h3E, 2'd0);
    step(NEXT, 6'h00, 2'd0);
    total++; if (upc !== 6'h3F) begin bad++; $display("FAIL next1 got %h want 3f", upc); end
    stall = 1'b1;
    step(NEXT, 6'h00, 2'd0);
    total++; if (upc !== 6'h3F) begin bad++; $display("FAIL stall1 got %h want 3f", upc); end
    step(NEXT, 6'h00, 2'd0);
    total++; if (upc !== 6'h3F) begin bad++; $display("FAIL stall2 got %h want 3f", upc); end
    stall = 1'b0;
    step(NEXT, 6'h00, 2'd0);
    total++; if (upc !== 6'h00) begin bad++; $display("FAIL next_wrap got %h want 00", upc); end
    step(NEXT, 6'h00, 2'd0);
    total++; if (upc !== 6'h01) begin bad++; $display("FAIL next3 got %h want 01", upc); end
  endtask

  task automatic test_dispatch();
    step(FTCH, 6'h00, 2'd0);
    rom_offset = 6'h15; uc_seq = DISP;
    #1;
    total++; if (dispatch !== 1'b1) begin bad++; $display("FAIL dispatch_pulse got %b want 1", dispatch); end
    @(posedge clk); #1;
    total++; if (upc !== 6'h15) begin bad++; $display("FAIL dispatch_upc got %h want 15", upc); end
    uc_seq = NEXT;
    #1;
    total++; if (dispatch !== 1'b0) begin bad++; $display("FAIL dispatch_drop got %b want 0", dispatch); end
    stall = 1'b1; rom_offset = 6'h3A; uc_seq = DISP;
    #1;
    total++; if (dispatch !== 1'b0) begin bad++; $display("FAIL dispatch_stall got %b want 0", dispatch); end
    @(posedge clk); #1;
    total++; if (upc !== 6'h15) begin bad++; $display("FAIL dispatch_stall_upc got %h want 15", upc); end
    stall = 1'b0;
  endtask

  task automatic test_cjump();
    step(JUMP, 6'h10, 2'd0);
    flag_z = 1'b1;
    step(CJMP, 6'h30, 2'd1);
    total++; if (upc !== 6'h30) begin bad++; $display("FAIL cjump_z1 got %h want 30", upc); end
    step(JUMP, 6'h10, 2'd0);
    flag_z = 1'b0;
    step(CJMP, 6'h30, 2'd1);
    total++; if (upc !== 6'h11) begin bad++; $display("FAIL cjump_z0 got %h want 11", upc); end
    flag_c = 1'b1;
    step(CJMP, 6'h2C, 2'd2);
    total++; if (upc !== 6'h2C) begin bad++; $display("FAIL cjump_c1 got %h want 2c", upc); end
    flag_n = 1'b0;
    step(CJMP, 6'h05, 2'd3);
    total++; if (upc !== 6'h2D) begin bad++; $display("FAIL cjump_n0 got %h want 2d", upc); end
    flag_c = 1'b0;
  endtask

  task automatic test_call_ret();
    step(JUMP, 6'h05, 2'd0);
    step(CALL, 6'h20, 2'd0);
    total++; if (upc !== 6'h20 || depth !== 3'd1) begin bad++; $display("FAIL call1 upc=%h depth=%0d want 20/1", upc, depth); end
    step(NEXT, 6'h00, 2'd0);
    step(CALL, 6'h22, 2'd0);
    step(CALL, 6'h23, 2'd0);
    step(CALL, 6'h30, 2'd0);
    total++; if (upc !== 6'h30 || depth !== 3'd4) begin bad++; $display("FAIL call4 upc=%h depth=%0d want 30/4", upc, depth); end
    step(RET, 6'h00, 2'd0);
    total++; if (upc !== 6'h24 || depth !== 3'd3) begin bad++; $display("FAIL ret1 upc=%h depth=%0d want 24/3", upc, depth); end
    step(RET, 6'h00, 2'd0);
    total++; if (upc !== 6'h23) begin bad++; $display("FAIL ret2 got %h want 23", upc); end
    step(RET, 6'h00, 2'd0);
    total++; if (upc !== 6'h22) begin bad++; $display("FAIL ret3 got %h want 22", upc); end
    step(RET, 6'h00, 2'd0);
    total++; if (upc !== 6'h06 || depth !== 3'd0) begin bad++; $display("FAIL ret4 upc=%h depth=%0d want 06/0", upc, depth); end
    for (int i = 0; i < 4; i++) step(CALL, 6'h10, 2'd0);
    step(CALL, 6'h38, 2'd0);
    total++; if (fault !== 1'b1 || upc !== 6'h10 || depth !== 3'd4)
      begin bad++; $display("FAIL overflow fault=%b upc=%h depth=%0d want 1/10/4", fault, upc, depth); end
    resume = 1'b1;
    step(NEXT, 6'h00, 2'd0);
    resume = 1'b0;
    total++; if (fault !== 1'b1 || upc !== 6'h10) begin bad++; $display("FAIL fault_frozen fault=%b upc=%h want 1/10", fault, upc); end
    do_reset();
  endtask

  task automatic test_halt();
    step(JUMP, 6'h08, 2'd0);
    step(HALT, 6'h00, 2'd0);
    total++; if (halted !== 1'b1 || upc !== 6'h08) begin bad++; $display("FAIL halt halted=%b upc=%h want 1/08", halted, upc); end
    step(NEXT, 6'h00, 2'd0);
    total++; if (halted !== 1'b1 || upc !== 6'h08) begin bad++; $display("FAIL halt_hold halted=%b upc=%h want 1/08", halted, upc); end
    stall = 1'b1; resume = 1'b1;
    step(NEXT, 6'h00, 2'd0);
    stall = 1'b0; resume = 1'b0;
    total++; if (halted !== 1'b0 || upc !== 6'h00) begin bad++; $display("FAIL resume halted=%b upc=%h want 0/00", halted, upc); end
    step(RET, 6'h00, 2'd0);
    total++; if (fault !== 1'b1 || upc !== 6'h00) begin bad++; $display("FAIL underflow fault=%b upc=%h want 1/00", fault, upc); end
    resume = 1'b1;
    step(JUMP, 6'h33, 2'd0);
    resume = 1'b0;
    total++; if (fault !== 1'b1 || halted !== 1'b0 || upc !== 6'h00)
      begin bad++; $display("FAIL resume_ignored fault=%b halted=%b upc=%h want 1/0/00", fault, halted, upc); end
    do_reset();
    #1;
    total++; if (fault !== 1'b0 || upc !== 6'h00) begin bad++; $display("FAIL fault_cleared fault=%b upc=%h want 0/00", fault, upc); end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; rom_offset = '0; uc_seq = NEXT; uc_target = '0;
    uc_cond = '0; flag_z = 1'b0; flag_c = 1'b0; flag_n = 1'b0; resume = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    test_reset();
    test_next();
    test_dispatch();
    test_cjump();
    test_call_ret();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
